// File: rtl/mem_pkg.sv
// Shared widths and controller state encoding for the memory responder slice.
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    LOAD,
    IDLE,
    WAIT,
    ACCESS
  } state_e;
endpackage

// File: rtl/mem_responder_if.sv
// CPU access bus, program-loader stream and debug state for mem_responder.
// CPU side: req is a level sampled only in IDLE; ready is a one-cycle completion pulse, rdata valid from that cycle on.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  state_e            dbg_state;

  modport slave (
    input  req, we, addr, wdata, load_valid, load_data, load_last,
    output rdata, ready, busy, load_ready, load_done, dbg_state
  );

  modport master (
    output req, we, addr, wdata, load_valid, load_data, load_last,
    input  rdata, ready, busy, load_ready, load_done, dbg_state
  );
endinterface

// File: rtl/mem_array.sv
// 256x8 single-port storage: synchronous write, registered read port that holds between reads.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  // Contents survive reset; only a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && en && we) mem[addr] <= wdata;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Wait-state memory slave for a simple CPU bus with an optional program loader.
// Define MEM_RESPONDER_LOADER_EN to build the loader; without it the block leaves reset in IDLE.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH       = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);
`ifdef MEM_RESPONDER_LOADER_EN
  localparam state_e RESET_STATE = LOAD;
`else
  localparam state_e RESET_STATE = IDLE;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ready_q, ready_d;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_RESPONDER_LOADER_EN
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic              load_done_q, load_done_d;
`else
  logic              unused_load;
  assign unused_load = ^{bus.load_valid, bus.load_data, bus.load_last};
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    ready_d   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
`ifdef MEM_RESPONDER_LOADER_EN
    load_ptr_d  = load_ptr_q;
    load_done_d = load_done_q;
`endif
    unique case (state_q)
      LOAD: begin
`ifdef MEM_RESPONDER_LOADER_EN
        if (bus.load_valid) begin
          mem_en     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = load_ptr_q;
          mem_wdata  = bus.load_data;
          load_ptr_d = load_ptr_q + 1'b1;
          // The pointer never wraps: the byte at the top address ends the load.
          if (bus.load_last || (load_ptr_q == '1)) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          we_d    = bus.we;
          wdata_d = bus.wdata;
          wait_d  = WAIT_INIT;
          state_d = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WAIT_W'(1)) state_d = ACCESS;
      end
      ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wait_q  <= '0;
      ready_q <= 1'b0;
`ifdef MEM_RESPONDER_LOADER_EN
      load_ptr_q  <= '0;
      load_done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
`ifdef MEM_RESPONDER_LOADER_EN
      load_ptr_q  <= load_ptr_d;
      load_done_q <= load_done_d;
`endif
    end
  end

  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign bus.rdata     = mem_rdata;
  assign bus.ready     = ready_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;
`ifdef MEM_RESPONDER_LOADER_EN
  assign bus.load_ready = (state_q == LOAD);
  assign bus.load_done  = load_done_q;
`else
  assign bus.load_ready = 1'b0;
  assign bus.load_done  = 1'b1;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states) share one stimulus stream,
// each checked every cycle against a transaction-timing model plus directed literal expectations.
module tb_mem_responder;
  import mem_pkg::*;

`ifdef MEM_RESPONDER_LOADER_EN
  localparam bit LOADER = 1'b1;
`else
  localparam bit LOADER = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req = 1'b0, we = 1'b0;
  logic [7:0] addr = '0, wdata = '0;
  logic       load_valid = 1'b0, load_last = 1'b0;
  logic [7:0] load_data = '0;
  bit         chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [2:0] rdy, bsy, lrdy, ldone;
  logic [7:0] rd [3];
  state_e     st [3];
  int         lat_exp [3] = '{1, 2, 4};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : 3;

    mem_responder_if bus ();
    assign bus.req        = req;
    assign bus.we         = we;
    assign bus.addr       = addr;
    assign bus.wdata      = wdata;
    assign bus.load_valid = load_valid;
    assign bus.load_data  = load_data;
    assign bus.load_last  = load_last;
    assign rdy[g]   = bus.ready;
    assign bsy[g]   = bus.busy;
    assign lrdy[g]  = bus.load_ready;
    assign ldone[g] = bus.load_done;
    assign rd[g]    = bus.rdata;
    assign st[g]    = bus.dbg_state;

    mem_responder #(.WAIT_STATES(W), .DEPTH(256)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Model: an accepted access completes exactly W+1 edges after its sampling edge.
    logic [7:0] m [256];
    bit         mk [256];
    int         n = 0, fin = 0, ptr = 0;
    bit         in_acc = 0, loading = 0, done = 0, e_rdy = 0, e_rk = 1;
    logic [7:0] e_rd = '0;
    bit         c_we = 0;
    logic [7:0] c_a = '0, c_d = '0;

    always @(posedge clk) begin
      n++;
      if (!rst_n) begin
        in_acc = 0; e_rdy = 0; e_rd = '0; e_rk = 1;
        loading = LOADER; done = !LOADER; ptr = 0;
      end else begin
        e_rdy = 0;
        if (loading) begin
          if (load_valid) begin
            m[ptr] = load_data; mk[ptr] = 1;
            if (load_last || ptr == 255) begin loading = 0; done = 1; end
            ptr++;
          end
        end else if (in_acc) begin
          if (n == fin) begin
            if (c_we) begin m[c_a] = c_d; mk[c_a] = 1; end
            else begin e_rd = m[c_a]; e_rk = mk[c_a]; end
            e_rdy = 1; in_acc = 0;
          end
        end else if (req) begin
          in_acc = 1; fin = n + W + 1; c_we = we; c_a = addr; c_d = wdata;
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("ws%0d.ready", W), 8'(bus.ready), 8'(e_rdy));
        chk($sformatf("ws%0d.busy", W), 8'(bus.busy), 8'(loading || in_acc));
        chk($sformatf("ws%0d.load_ready", W), 8'(bus.load_ready), 8'(loading));
        chk($sformatf("ws%0d.load_done", W), 8'(bus.load_done), 8'(done));
        if (e_rk) chk($sformatf("ws%0d.rdata", W), bus.rdata, e_rd);
      end
    end
  end

  // driver tasks
  task automatic access(input bit w, input logic [7:0] a, input logic [7:0] d, input bit jam);
    int first [3];
    int cnt [3];
    first = '{0, 0, 0};
    cnt   = '{0, 0, 0};
    we = w; addr = a; wdata = d; req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (rdy[g]) begin
          cnt[g]++;
          if (first[g] == 0) first[g] = k;
        end
      end
      if (jam) begin
        addr = addr ^ 8'hFF;
        req  = (k == 2);
      end
    end
    for (int g = 0; g < 3; g++) chk($sformatf("latency[%0d]", g), 8'(first[g] - 1), 8'(lat_exp[g]));
    if (jam) chk("jam_single_ready_ws3", 8'(cnt[2]), 8'd1);
  endtask

  task automatic load_stream(input int cnt, input int last_at, input logic [7:0] base, input bit xr);
    for (int i = 0; i < cnt; i++) begin
      load_valid = 1'b1;
      load_data  = xr ? (8'(i) ^ 8'h5A) : (base + 8'(i));
      load_last  = (i == last_at);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s.ready[%0d]", tag, g), 8'(rdy[g]), 8'd0);
      chk($sformatf("%s.rdata[%0d]", tag, g), rd[g], 8'h00);
      chk($sformatf("%s.busy[%0d]", tag, g), 8'(bsy[g]), 8'(LOADER));
      chk($sformatf("%s.load_ready[%0d]", tag, g), 8'(lrdy[g]), 8'(LOADER));
      chk($sformatf("%s.load_done[%0d]", tag, g), 8'(ldone[g]), 8'(!LOADER));
      chk($sformatf("%s.state[%0d]", tag, g), 8'(st[g]), 8'(LOADER ? LOAD : IDLE));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset_checks("reset");
    rst_n = 1'b1;

`ifdef MEM_RESPONDER_LOADER_EN
    // req held during LOAD must not produce a ready
    req = 1'b1; we = 1'b0; addr = 8'h02;
    load_stream(4, 3, 8'hA0, 1'b0);
    req = 1'b0;
    chk("load_done_after_last", 8'(ldone[1]), 8'd1);
    repeat (8) @(negedge clk);
`endif

    access(1'b1, 8'h20, 8'h11, 1'b0);
    access(1'b0, 8'h02, 8'h00, 1'b0);
`ifdef MEM_RESPONDER_LOADER_EN
    chk("loaded_read_addr2_ws1", rd[1], 8'hA2);
`endif

    // back-to-back write then read on the zero-wait instance
    req = 1'b1; we = 1'b1; addr = 8'h10; wdata = 8'h5C;
    @(negedge clk); we = 1'b0;
    chk("b2b_k1_ready", 8'(rdy[0]), 8'd0);
    @(negedge clk);
    chk("b2b_k2_ready", 8'(rdy[0]), 8'd1);
    @(negedge clk);
    chk("b2b_k3_ready", 8'(rdy[0]), 8'd0);
    @(negedge clk);
    chk("b2b_k4_ready", 8'(rdy[0]), 8'd1);
    chk("b2b_rdata", rd[0], 8'h5C);
    req = 1'b0;
    repeat (6) @(negedge clk);

    // address toggled during WAIT must not affect the captured access
    access(1'b1, 8'h40, 8'h3C, 1'b0);
    access(1'b1, 8'hBF, 8'h99, 1'b0);
    access(1'b0, 8'h40, 8'h00, 1'b1);
    chk("jam_captured_addr_ws3", rd[2], 8'h3C);

    // reset while the write to 0x20 is still pending
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h77;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    reset_checks("midreset");
    rst_n = 1'b1;

`ifdef MEM_RESPONDER_LOADER_EN
    req = 1'b1; we = 1'b0; addr = 8'h00;
    load_stream(256, -1, 8'h00, 1'b1);
    load_valid = 1'b1; load_data = 8'hEE;
    @(negedge clk);
    load_valid = 1'b0; req = 1'b0;
    chk("full_load_done", 8'(ldone[2]), 8'd1);
    repeat (8) @(negedge clk);
    access(1'b0, 8'h00, 8'h00, 1'b0);
    chk("full_load_mem0_intact", rd[0], 8'h5A);
`endif

    access(1'b0, 8'h20, 8'h00, 1'b0);
    for (int g = 0; g < 3; g++) begin
`ifdef MEM_RESPONDER_LOADER_EN
      chk($sformatf("addr20_reloaded[%0d]", g), rd[g], 8'h7A);
`else
      chk($sformatf("addr20_old_value[%0d]", g), rd[g], 8'h11);
`endif
    end

    access(1'b0, 8'h10, 8'h00, 1'b0);
    chk("addr10_ws1", rd[1], 8'h5C);

    // load inputs outside LOAD must not disturb memory
    access(1'b1, 8'h01, 8'h66, 1'b0);
    load_stream(4, 3, 8'hC0, 1'b0);
    repeat (4) @(negedge clk);
    access(1'b0, 8'h01, 8'h00, 1'b0);
    for (int g = 0; g < 3; g++) chk($sformatf("load_ignored[%0d]", g), rd[g], 8'h66);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
